hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Hazard and sequencing controller for the 5-stage RV32I pipeline (stage0 PC .. stage4 WB regs).
//  Decodes the instruction held in each pipeline register and drives the PC/IF-ID stall,
//  the ID-EX bubble, the IF-ID flush and the EX operand-forward selects.
//  Sequences multi-cycle data-memory waits and keeps saturating stall/flush event counters.
// PARAMETERS
//  MEM_TIMEOUT  16   max cycles to wait on dmem_ready before forced release (>=1)
//  CNT_W        16   width of each perf counter
// PORTS
//  clk          in   1      single clock; all state updates on falling edge, same as pipeline regs
//  rst          in   1      synchronous, active-high reset
//  id_inst      in   32     instruction in IF/ID register (stage1 inst)
//  ex_inst      in   32     instruction in ID/EX register (stage2 inst)
//  mem_inst     in   32     instruction in EX/MEM register (stage3 inst)
//  wb_inst      in   32     instruction in MEM/WB register (stage4 inst)
//  ex_redirect  in   1      EX resolved taken branch / JAL / JALR this cycle
//  dmem_ready   in   1      data memory done; sampled only while mem_inst is LOAD/STORE
//  stall_pc     out  1      hold PC register (stage0 stall)
//  stall_ifid   out  1      hold IF/ID register
//  bubble_idex  out  1      force NOP 32'h00000033 into ID/EX
//  flush_ifid   out  1      force NOP into IF/ID
//  freeze       out  1      hold every pipeline register (memory wait)
//  fwd_a        out  2      EX rs1 source: 00 regfile, 01 EX/MEM alu, 10 MEM/WB result
//  fwd_b        out  2      EX rs2 source, same encoding
//  mem_timeout  out  1      sticky: a memory wait hit MEM_TIMEOUT
//  stall_cnt    out  CNT_W  cycles with stall_pc or freeze high, saturating
//  flush_cnt    out  CNT_W  cycles with flush_ifid high, saturating
// BEHAVIOUR
//  - Decode: opcode=[6:0], rd=[11:7], rs1=[19:15], rs2=[24:20].
//    rs1 used by R/I/S/B/JALR. rs2 used by R/S/B. rd written by R/I/LOAD/JAL/JALR/LUI/AUIPC.
//    rd==0 never matches.
//  - FSM states: RUN, LU_STALL, MEM_WAIT. Reset -> RUN; outputs 0; counters 0; mem_timeout 0.
//  - RUN: priority order, highest first:
//    1) mem_inst is LOAD/STORE and !dmem_ready: freeze=1, wait counter=1, -> MEM_WAIT.
//    2) ex_redirect: flush_ifid=1, bubble_idex=1, no stall; stay RUN. Redirect beats load-use.
//    3) ex_inst LOAD, its rd == a used rs1/rs2 of id_inst: stall_pc=stall_ifid=bubble_idex=1,
//       -> LU_STALL.
//    4) otherwise all controls 0.
//  - LU_STALL: exactly one stall cycle per load-use; controls 0; -> RUN. Hazard is then covered
//    by MEM/WB forward. A second back-to-back load-use re-enters per RUN rules next cycle.
//  - MEM_WAIT: freeze=1 (overrides stall/bubble/flush; those read 0); ex_redirect ignored,
//    since EX is held.
//    dmem_ready=1 -> freeze=0 that cycle, -> RUN.
//    Wait counter reaches MEM_TIMEOUT -> set mem_timeout, release freeze, -> RUN.
//  - Forwarding, combinational from ex_inst rs vs mem_inst/wb_inst rd:
//    EX/MEM match (writer, not LOAD) -> 01; else MEM/WB match -> 10; else 00.
//    EX/MEM beats MEM/WB. STORE/BRANCH never count as writers.
//  - Counters: +1 per qualifying cycle, hold at 2^CNT_W-1. Cleared only by rst.
//  - rst in any state: next edge -> RUN, all outputs 0 the same cycle rst is sampled.
// TESTING
//  - LW x5 in ex_inst, ADD x6,x5,x1 in id_inst -> stall_pc/stall_ifid/bubble_idex=1 for 1 cycle,
//    then 0; then fwd_a=10; stall_cnt=1.
//  - LW x0 in EX, consumer uses x0 -> no stall. SW rs2=x5 after LW x5 -> stall (rs2 used).
//  - ex_redirect=1 with load-use present -> flush_ifid=bubble_idex=1, stall_pc=0; flush_cnt=1.
//  - LW in mem_inst, dmem_ready low 3 cycles -> freeze=1 for 3 cycles, 0 on the 4th;
//    mem_timeout=0.
//  - MEM_TIMEOUT=4, dmem_ready held 0 -> freeze 4 cycles, then mem_timeout=1 and RUN.
//  - ADDI x3 in mem_inst and in wb_inst, ADD x7,x3,x3 in EX -> fwd_a=fwd_b=01.
//    rst mid-MEM_WAIT -> all outputs 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage RV32I pipeline.
// Generates load-use stalls, redirect flushes, memory-wait freezes and
// EX operand forwarding selects, and counts stall/flush cycles.
// All state updates on the falling clock edge, in step with the pipeline registers.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_inst,
  input  logic [31:0]      ex_inst,
  input  logic [31:0]      mem_inst,
  input  logic [31:0]      wb_inst,
  input  logic             ex_redirect,
  input  logic             dmem_ready,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              timeout_set;
  logic              mem_timeout_q;
  logic [CNT_W-1:0]  stall_q, flush_q;
  logic              stall_c, bubble_c, flush_c, freeze_c;
  logic [1:0]        fwd_a_c, fwd_b_c;
  logic              load_use;
  logic              mem_is_ls;

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_IMM) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_JALR);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_IMM) || (op == OP_LOAD) || (op == OP_JAL) ||
           (op == OP_JALR) || (op == OP_LUI) || (op == OP_AUIPC);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Forward select for one EX source register; the EX/MEM stage wins over MEM/WB,
  // and a load in EX/MEM has no result yet so it cannot forward.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic used);
    logic [1:0] sel;
    sel = 2'b00;
    if (used && rs != 5'd0) begin
      if (writes_rd(mem_inst[6:0]) && mem_inst[6:0] != OP_LOAD && mem_inst[11:7] == rs)
        sel = 2'b01;
      else if (writes_rd(wb_inst[6:0]) && wb_inst[11:7] == rs)
        sel = 2'b10;
    end
    return sel;
  endfunction

  logic unused_bits;
  assign unused_bits = ^{id_inst[31:25], id_inst[14:7], ex_inst[31:25], ex_inst[14:12],
                         mem_inst[31:12], wb_inst[31:12]};

  assign mem_is_ls = (mem_inst[6:0] == OP_LOAD) || (mem_inst[6:0] == OP_STORE);

  assign load_use = (ex_inst[6:0] == OP_LOAD) && (ex_inst[11:7] != 5'd0) &&
                    ((uses_rs1(id_inst[6:0]) && id_inst[19:15] == ex_inst[11:7]) ||
                     (uses_rs2(id_inst[6:0]) && id_inst[24:20] == ex_inst[11:7]));

  assign fwd_a_c = fwd_sel(ex_inst[19:15], uses_rs1(ex_inst[6:0]));
  assign fwd_b_c = fwd_sel(ex_inst[24:20], uses_rs2(ex_inst[6:0]));

  // Next-state and control decode; memory wait beats redirect beats load-use.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    stall_c      = 1'b0;
    bubble_c     = 1'b0;
    flush_c      = 1'b0;
    freeze_c     = 1'b0;
    timeout_set  = 1'b0;
    case (state)
      RUN: begin
        if (mem_is_ls && !dmem_ready) begin
          freeze_c     = 1'b1;
          wait_cnt_nxt = WAIT_W'(1);
          state_nxt    = MEM_WAIT;
        end else if (ex_redirect) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (load_use) begin
          stall_c   = 1'b1;
          bubble_c  = 1'b1;
          state_nxt = LU_STALL;
        end
      end
      LU_STALL: state_nxt = RUN;
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt = RUN;
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
          timeout_set = 1'b1;
          state_nxt   = RUN;
        end else begin
          freeze_c     = 1'b1;
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // State, wait counter, sticky timeout flag and saturating event counters.
  always_ff @(negedge clk) begin
    if (rst) begin
      state         <= RUN;
      wait_cnt      <= '0;
      mem_timeout_q <= 1'b0;
      stall_q       <= '0;
      flush_q       <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (timeout_set)
        mem_timeout_q <= 1'b1;
      if (stall_c || freeze_c)
        stall_q <= sat_inc(stall_q);
      if (flush_c)
        flush_q <= sat_inc(flush_q);
    end
  end

  // Reset forces every output low in the same cycle it is sampled.
  assign stall_pc    = !rst && stall_c;
  assign stall_ifid  = !rst && stall_c;
  assign bubble_idex = !rst && bubble_c;
  assign flush_ifid  = !rst && flush_c;
  assign freeze      = !rst && freeze_c;
  assign fwd_a       = rst ? 2'b00 : fwd_a_c;
  assign fwd_b       = rst ? 2'b00 : fwd_b_c;
  assign mem_timeout = !rst && mem_timeout_q;
  assign stall_cnt   = rst ? '0 : stall_q;
  assign flush_cnt   = rst ? '0 : flush_q;

endmodule
